nibble_stats_acc: RTL and testbench
===================================

# nibble_stats_acc

Frame-level statistics accumulator for the nibble classifier path. It sits directly downstream of the 4-bit prime / divisible-by-3 detector and consumes a stream of nibbles together with their P (prime) and D (divisible-by-3) flags. It accumulates per-frame counts and a nibble sum, then presents one result record per frame on a valid/ready output port.

## Interface
- CNT_W, default 8: width of every count output. The sum output is CNT_W+4 bits wide.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_nibble  in  4  nibble value.
- in_p  in  1  prime flag from the detector.
- in_d  in  1  divisible-by-3 flag from the detector.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the record.
- out_total  out  CNT_W  beats in the frame.
- out_prime_cnt  out  CNT_W  beats with in_p=1.
- out_div3_cnt  out  CNT_W  beats with in_d=1.
- out_both_cnt  out  CNT_W  beats with in_p=1 and in_d=1.
- out_sum  out  CNT_W+4  sum of in_nibble over the frame.
- out_sat  out  1  some counter or the sum saturated during the frame.
- out_flag_err  out  1  flag/value mismatch seen in the frame (see Configuration).

## Operation
- Two states:
  - ACC: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- A beat is accepted when in_valid & in_ready. Inputs are ignored while in_valid=0.
- On each accepted beat, the internal accumulators update:
  - total+1.
  - prime+in_p.
  - div3+in_d.
  - both+(in_p&in_d).
  - sum+in_nibble.
- Counts use the flags exactly as received. The block does not recompute them.
- All accumulators saturate at all-ones and never wrap. The sum saturates at 2^(CNT_W+4)-1.
- Any increment attempted at all-ones sets the sticky frame flag sat.
- Accepted beat with in_last=1:
  - The updated values, including that beat, load into the output registers.
  - The accumulators and sticky flags clear.
  - The state moves ACC->HOLD.
- HOLD:
  - Output registers hold stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, the state moves HOLD->ACC.
  - out_valid drops on that edge.
  - Output data registers keep their last values until the next record loads.
- A single-beat frame (in_last on the first beat) is legal.
- Reset (any time, including mid-frame or in HOLD) immediately does all of the following:
  - Clears accumulators, sticky flags, and all outputs to 0.
  - Forces the state to ACC.
  - Drives in_ready to 1 after deassertion.
  - Discards any partial frame.

## Timing
- Reset values:
  - out_valid=0.
  - All count, sum, out_sat, and out_flag_err outputs = 0.
  - in_ready=1.
- Latency: if the last beat is accepted at edge N, out_valid=1 and the record are visible after edge N.
- Ready coupling:
  - in_ready=0 from edge N until the accepting edge M.
  - in_ready=1 after edge M.
  - There is no combinational path from out_ready to in_ready.
- Throughput:
  - One beat per cycle within a frame.
  - At least one non-accepting cycle between frames.
- All outputs are registered.

## Configuration
- Macro: NIBBLE_STATS_CHECK_EN.
- Defined:
  - Each accepted beat is checked against the reference sets: prime = {2,3,5,7,11,13}, divisible-by-3 = {0,3,6,9,12,15}.
  - Any in_p or in_d disagreement sets a sticky frame error.
  - The error is reported on out_flag_err with the record and cleared with the accumulators.
- Not defined:
  - No checker logic exists.
  - out_flag_err is constant 0.

## Test plan
- Frame with nibbles 2, 3, 4, 9 (last on 9) and correct flags, out_ready=1 -> single record:
  - total=4, prime=2, div3=2, both=1, sum=18, sat=0, flag_err=0.
  - out_valid high for 1 cycle.
- Same frame with out_ready held 0 for 5 cycles after out_valid:
  - Record stable throughout and in_ready=0.
  - Beats offered during HOLD are not counted.
  - in_ready=1 the cycle after acceptance.
- Single-beat frame, nibble 0, in_d=1, in_last=1 -> total=1, prime=0, div3=1, both=0, sum=0.
- CNT_W=4, 20 beats of nibble 15 with in_d=1:
  - total=15, div3=15, sum=255, sat=1.
  - The next frame starts with sat=0.
- Nibble 4 with in_p=1 as a 1-beat frame -> flag_err=1 with NIBBLE_STATS_CHECK_EN defined, 0 without; prime=1 in both builds.
- rst_n pulsed low after 2 beats of a frame:
  - All outputs become 0 immediately.
  - A following 1-beat frame with nibble 5 reports total=1, prime=1, sum=5.

Source files
------------

// File: rtl/nibble_stats_acc_if.sv
// rtl/nibble_stats_acc_if.sv - beat input and record output bundle for nibble_stats_acc
interface nibble_stats_acc_if #(
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_nibble;
  logic               in_p;
  logic               in_d;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   out_total;
  logic [CNT_W-1:0]   out_prime_cnt;
  logic [CNT_W-1:0]   out_div3_cnt;
  logic [CNT_W-1:0]   out_both_cnt;
  logic [CNT_W+3:0]   out_sum;
  logic               out_sat;
  logic               out_flag_err;

  // Producer of beats and consumer of records
  modport master (
    output in_valid, in_nibble, in_p, in_d, in_last, out_ready,
    input  in_ready, out_valid, out_total, out_prime_cnt, out_div3_cnt,
           out_both_cnt, out_sum, out_sat, out_flag_err
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_nibble, in_p, in_d, in_last, out_ready,
    output in_ready, out_valid, out_total, out_prime_cnt, out_div3_cnt,
           out_both_cnt, out_sum, out_sat, out_flag_err
  );
endinterface

// File: rtl/nibble_stats_acc.sv
// rtl/nibble_stats_acc.sv - per-frame nibble statistics accumulator; optional flag checker under NIBBLE_STATS_CHECK_EN
module nibble_stats_acc #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  nibble_stats_acc_if.slave bus
);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_prime;
  logic [CNT_W-1:0] r_div3;
  logic [CNT_W-1:0] r_both;
  logic [CNT_W+3:0] r_sum;
  logic             r_sat;

  logic [CNT_W-1:0] r_o_total;
  logic [CNT_W-1:0] r_o_prime;
  logic [CNT_W-1:0] r_o_div3;
  logic [CNT_W-1:0] r_o_both;
  logic [CNT_W+3:0] r_o_sum;
  logic             r_o_sat;

  logic             w_accept;
  logic             w_both_inc;
  logic [CNT_W-1:0] w_total_nx;
  logic [CNT_W-1:0] w_prime_nx;
  logic [CNT_W-1:0] w_div3_nx;
  logic [CNT_W-1:0] w_both_nx;
  logic [CNT_W+4:0] w_sum_wide;
  logic [CNT_W+3:0] w_sum_nx;
  logic             w_sat_nx;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_both_inc = bus.in_p & bus.in_d;

  // Saturating next values of every accumulator, including the beat currently offered
  always_comb begin
    w_total_nx = (&r_total) ? r_total : r_total + ONE;
    w_prime_nx = (bus.in_p && !(&r_prime)) ? r_prime + ONE : r_prime;
    w_div3_nx  = (bus.in_d && !(&r_div3))  ? r_div3 + ONE  : r_div3;
    w_both_nx  = (w_both_inc && !(&r_both)) ? r_both + ONE : r_both;
    w_sum_wide = {1'b0, r_sum} + {{(CNT_W+1){1'b0}}, bus.in_nibble};
    w_sum_nx   = w_sum_wide[CNT_W+4] ? {(CNT_W+4){1'b1}} : w_sum_wide[CNT_W+3:0];
    w_sat_nx   = r_sat
               | (&r_total)
               | (bus.in_p & (&r_prime))
               | (bus.in_d & (&r_div3))
               | (w_both_inc & (&r_both))
               | w_sum_wide[CNT_W+4];
  end

`ifdef NIBBLE_STATS_CHECK_EN
  logic r_err;
  logic r_o_err;
  logic w_ref_p;
  logic w_ref_d;
  logic w_err_nx;

  // Reference prime and divisible-by-3 sets for a 4-bit value
  always_comb begin
    w_ref_p = 1'b0;
    w_ref_d = 1'b0;
    case (bus.in_nibble)
      4'd2, 4'd5, 4'd7, 4'd11, 4'd13: w_ref_p = 1'b1;
      4'd3:                           begin w_ref_p = 1'b1; w_ref_d = 1'b1; end
      4'd0, 4'd6, 4'd9, 4'd12, 4'd15: w_ref_d = 1'b1;
      default:                        ;
    endcase
    w_err_nx = r_err | (bus.in_p ^ w_ref_p) | (bus.in_d ^ w_ref_d);
  end

  assign bus.out_flag_err = r_o_err;
`else
  assign bus.out_flag_err = 1'b0;
`endif

  // Frame FSM: accumulate in ACC, present the record in HOLD until the consumer takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_total     <= '0;
      r_prime     <= '0;
      r_div3      <= '0;
      r_both      <= '0;
      r_sum       <= '0;
      r_sat       <= 1'b0;
      r_o_total   <= '0;
      r_o_prime   <= '0;
      r_o_div3    <= '0;
      r_o_both    <= '0;
      r_o_sum     <= '0;
      r_o_sat     <= 1'b0;
`ifdef NIBBLE_STATS_CHECK_EN
      r_err       <= 1'b0;
      r_o_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            if (bus.in_last) begin
              r_o_total   <= w_total_nx;
              r_o_prime   <= w_prime_nx;
              r_o_div3    <= w_div3_nx;
              r_o_both    <= w_both_nx;
              r_o_sum     <= w_sum_nx;
              r_o_sat     <= w_sat_nx;
              r_total     <= '0;
              r_prime     <= '0;
              r_div3      <= '0;
              r_both      <= '0;
              r_sum       <= '0;
              r_sat       <= 1'b0;
`ifdef NIBBLE_STATS_CHECK_EN
              r_o_err     <= w_err_nx;
              r_err       <= 1'b0;
`endif
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_total <= w_total_nx;
              r_prime <= w_prime_nx;
              r_div3  <= w_div3_nx;
              r_both  <= w_both_nx;
              r_sum   <= w_sum_nx;
              r_sat   <= w_sat_nx;
`ifdef NIBBLE_STATS_CHECK_EN
              r_err   <= w_err_nx;
`endif
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ACC;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_total     = r_o_total;
  assign bus.out_prime_cnt = r_o_prime;
  assign bus.out_div3_cnt  = r_o_div3;
  assign bus.out_both_cnt  = r_o_both;
  assign bus.out_sum       = r_o_sum;
  assign bus.out_sat       = r_o_sat;

endmodule

// File: tb/tb_nibble_stats_acc.sv
// tb/tb_nibble_stats_acc.sv - directed self-checking bench for nibble_stats_acc
module tb_nibble_stats_acc;

`ifdef NIBBLE_STATS_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  nibble_stats_acc_if #(.CNT_W(8)) bus8();
  nibble_stats_acc_if #(.CNT_W(4)) bus4();

  nibble_stats_acc #(.CNT_W(8)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8.slave));
  nibble_stats_acc #(.CNT_W(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4.slave));

  // Record packed as {total, prime, div3, both, sum, sat, flag_err}
  logic [45:0] rec8;
  logic [25:0] rec4;
  assign rec8 = {bus8.out_total, bus8.out_prime_cnt, bus8.out_div3_cnt, bus8.out_both_cnt,
                 bus8.out_sum, bus8.out_sat, bus8.out_flag_err};
  assign rec4 = {bus4.out_total, bus4.out_prime_cnt, bus4.out_div3_cnt, bus4.out_both_cnt,
                 bus4.out_sum, bus4.out_sat, bus4.out_flag_err};

  task automatic beat8(input logic [3:0] n, input logic p, input logic d, input logic last);
    logic acc;
    int   waited;
    bus8.in_valid = 1'b1; bus8.in_nibble = n; bus8.in_p = p; bus8.in_d = d; bus8.in_last = last;
    waited = 0;
    do begin
      acc = bus8.in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 20);
    bus8.in_valid = 1'b0;
    if (!acc) begin
      n_total++; n_bad++;
      $display("FAIL beat8_timeout nibble=%0d never accepted", n);
    end
  endtask

  task automatic beat4(input logic [3:0] n, input logic p, input logic d, input logic last);
    logic acc;
    int   waited;
    bus4.in_valid = 1'b1; bus4.in_nibble = n; bus4.in_p = p; bus4.in_d = d; bus4.in_last = last;
    waited = 0;
    do begin
      acc = bus4.in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 20);
    bus4.in_valid = 1'b0;
    if (!acc) begin
      n_total++; n_bad++;
      $display("FAIL beat4_timeout nibble=%0d never accepted", n);
    end
  endtask

  task automatic test_reset();
    logic [45:0] e8;
    logic [25:0] e4;
    e8 = '0; e4 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus8.out_valid); end
    n_total++; if (rec8 !== e8) begin n_bad++; $display("FAIL reset_rec8 got=%h exp=%h", rec8, e8); end
    n_total++; if (rec4 !== e4) begin n_bad++; $display("FAIL reset_rec4 got=%h exp=%h", rec4, e4); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
    n_total++; if (bus4.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready4 got=%b exp=1", bus4.in_ready); end
  endtask

  task automatic test_basic();
    logic [45:0] e;
    e = {8'd4, 8'd2, 8'd2, 8'd1, 12'd18, 1'b0, 1'b0};
    bus8.out_ready = 1'b1;
    beat8(4'd2, 1'b1, 1'b0, 1'b0);
    beat8(4'd3, 1'b1, 1'b1, 1'b0);
    beat8(4'd4, 1'b0, 1'b0, 1'b0);
    beat8(4'd9, 1'b0, 1'b1, 1'b1);
    n_total++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", bus8.out_valid); end
    n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL basic_rec got=%h exp=%h", rec8, e); end
    n_total++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready got=%b exp=0", bus8.in_ready); end
    @(posedge clk); #1;
    n_total++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got=%b exp=0", bus8.out_valid); end
    n_total++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back got=%b exp=1", bus8.in_ready); end
    n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL basic_rec_kept got=%h exp=%h", rec8, e); end
  endtask

  task automatic test_hold();
    logic [45:0] e;
    e = {8'd4, 8'd2, 8'd2, 8'd1, 12'd18, 1'b0, 1'b0};
    bus8.out_ready = 1'b0;
    beat8(4'd2, 1'b1, 1'b0, 1'b0);
    beat8(4'd3, 1'b1, 1'b1, 1'b0);
    beat8(4'd4, 1'b0, 1'b0, 1'b0);
    beat8(4'd9, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1; bus8.in_nibble = 4'd7; bus8.in_p = 1'b1; bus8.in_d = 1'b0; bus8.in_last = 1'b1;
      @(posedge clk); #1;
      n_total++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus8.out_valid); end
      n_total++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus8.in_ready); end
      n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL hold_rec[%0d] got=%h exp=%h", i, rec8, e); end
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_valid got=%b exp=0", bus8.out_valid); end
    n_total++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready got=%b exp=1", bus8.in_ready); end
  endtask

  task automatic test_single_beat();
    logic [45:0] e;
    e = {8'd1, 8'd0, 8'd1, 8'd0, 12'd0, 1'b0, 1'b0};
    bus8.out_ready = 1'b1;
    beat8(4'd0, 1'b0, 1'b1, 1'b1);
    n_total++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", bus8.out_valid); end
    n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL single_rec got=%h exp=%h", rec8, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_flag_err();
    logic [45:0] e;
    e = {8'd1, 8'd1, 8'd0, 8'd0, 12'd4, 1'b0, EXP_CHK};
    bus8.out_ready = 1'b1;
    beat8(4'd4, 1'b1, 1'b0, 1'b1);
    n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL flag_err_rec got=%h exp=%h", rec8, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [45:0] ea;
    logic [45:0] eb;
    ea = {8'd2, 8'd1, 8'd0, 8'd0, 12'd3, 1'b0, 1'b0};
    eb = {8'd1, 8'd0, 8'd1, 8'd0, 12'd6, 1'b0, 1'b0};
    bus8.out_ready = 1'b1;
    beat8(4'd1, 1'b0, 1'b0, 1'b0);
    beat8(4'd2, 1'b1, 1'b0, 1'b1);
    n_total++; if (rec8 !== ea) begin n_bad++; $display("FAIL b2b_rec_a got=%h exp=%h", rec8, ea); end
    beat8(4'd6, 1'b0, 1'b1, 1'b1);
    n_total++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_b got=%b exp=1", bus8.out_valid); end
    n_total++; if (rec8 !== eb) begin n_bad++; $display("FAIL b2b_rec_b got=%h exp=%h", rec8, eb); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [25:0] e;
    logic [25:0] e2;
    e  = {4'd15, 4'd0, 4'd15, 4'd0, 8'd255, 1'b1, 1'b0};
    e2 = {4'd1, 4'd1, 4'd0, 4'd0, 8'd5, 1'b0, 1'b0};
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) beat4(4'd15, 1'b0, 1'b1, 1'b0);
    beat4(4'd15, 1'b0, 1'b1, 1'b1);
    n_total++; if (rec4 !== e) begin n_bad++; $display("FAIL sat_rec got=%h exp=%h", rec4, e); end
    @(posedge clk); #1;
    beat4(4'd5, 1'b1, 1'b0, 1'b1);
    n_total++; if (rec4 !== e2) begin n_bad++; $display("FAIL sat_next_rec got=%h exp=%h", rec4, e2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [45:0] e;
    logic [45:0] z8;
    logic [25:0] z4;
    e = {8'd1, 8'd1, 8'd0, 8'd0, 12'd5, 1'b0, 1'b0};
    z8 = '0; z4 = '0;
    bus8.out_ready = 1'b1;
    beat8(4'd2, 1'b1, 1'b0, 1'b0);
    beat8(4'd3, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_total++; if (rec8 !== z8) begin n_bad++; $display("FAIL rstmid_rec8 got=%h exp=%h", rec8, z8); end
    n_total++; if (rec4 !== z4) begin n_bad++; $display("FAIL rstmid_rec4 got=%h exp=%h", rec4, z4); end
    n_total++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%b exp=0", bus8.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat8(4'd5, 1'b1, 1'b0, 1'b1);
    n_total++; if (rec8 !== e) begin n_bad++; $display("FAIL rstmid_after_rec got=%h exp=%h", rec8, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.in_nibble = 4'd0; bus8.in_p = 1'b0; bus8.in_d = 1'b0; bus8.in_last = 1'b0;
    bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_nibble = 4'd0; bus4.in_p = 1'b0; bus4.in_d = 1'b0; bus4.in_last = 1'b0;
    bus4.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_single_beat();
    test_flag_err();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
